// File: rtl/alu_exec_unit.sv
// MIPS execute-stage ALU with a one-deep registered, valid/ready result slot.
// Define ALU_MULDIV_EN to add the iterative MULTU path (MUL/DONE states, hi word).
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             illegal
);

    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR,
        OP_SLT, OP_SLL, OP_SRL, OP_MULTU, OP_ILL
    } op_e;

    op_e              op;
    logic [WIDTH-1:0] alu_res;
    logic             is_mul;
    logic             in_fire;
    logic             mul_busy;
    logic             mul_done;
    logic [WIDTH-1:0] prod_lo;
    logic [WIDTH-1:0] prod_hi;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             zero_q, zero_d;
    logic             illegal_q, illegal_d;

    always_comb begin
        op = OP_ILL;
        case (alu_op)
            2'b01, 2'b10: op = OP_ADD;
            2'b11:        op = OP_SUB;
            default: begin
                case (funct)
                    6'b100000: op = OP_ADD;
                    6'b100010: op = OP_SUB;
                    6'b100100: op = OP_AND;
                    6'b100101: op = OP_OR;
                    6'b100111: op = OP_NOR;
                    6'b101010: op = OP_SLT;
                    6'b000000: op = OP_SLL;
                    6'b000010: op = OP_SRL;
`ifdef ALU_MULDIV_EN
                    6'b011001: op = OP_MULTU;
`endif
                    default:   op = OP_ILL;
                endcase
            end
        endcase
    end

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD: alu_res = a + b;
            OP_SUB: alu_res = a - b;
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_NOR: alu_res = ~(a | b);
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLL: alu_res = a << b[SHW-1:0];
            OP_SRL: alu_res = a >> b[SHW-1:0];
            default: alu_res = '0;
        endcase
    end

    assign is_mul   = (op == OP_MULTU);
    assign in_ready = !mul_busy && (!out_valid_q || out_ready);
    assign in_fire  = in_valid && in_ready;

`ifdef ALU_MULDIV_EN
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_e;

    state_e             state_q, state_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH:0]     step_sum;

    // Right-shifting shift-add: the multiplier sits in the low half of prod_q
    // and is consumed one bit per step while the partial product grows from the top.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        step_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        case (state_q)
            S_IDLE: begin
                if (in_fire && is_mul) begin
                    state_d = S_MUL;
                    cnt_d   = '0;
                    mcand_d = a;
                    prod_d  = {{WIDTH{1'b0}}, b};
                end
            end
            S_MUL: begin
                prod_d = {step_sum, prod_q[WIDTH-1:1]};
                cnt_d  = cnt_q + SHW'(1);
                if (cnt_q == SHW'(WIDTH-1)) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
        end
    end

    assign mul_busy = (state_q != S_IDLE);
    assign mul_done = (state_q == S_DONE);
    assign prod_lo  = prod_q[WIDTH-1:0];
    assign prod_hi  = prod_q[2*WIDTH-1:WIDTH];
`else
    assign mul_busy = 1'b0;
    assign mul_done = 1'b0;
    assign prod_lo  = '0;
    assign prod_hi  = '0;
`endif

    // Accepting a multiply frees the slot; its result lands later from DONE.
    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        hi_d        = hi_q;
        zero_d      = zero_q;
        illegal_d   = illegal_q;
        if (in_fire) begin
            if (is_mul) begin
                out_valid_d = 1'b0;
            end else begin
                out_valid_d = 1'b1;
                result_d    = alu_res;
                hi_d        = '0;
                zero_d      = (alu_res == '0);
                illegal_d   = (op == OP_ILL);
            end
        end else if (mul_done) begin
            out_valid_d = 1'b1;
            result_d    = prod_lo;
            hi_d        = prod_hi;
            zero_d      = (prod_lo == '0);
            illegal_d   = 1'b0;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            hi_q        <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            hi_q        <= hi_d;
            zero_q      <= zero_d;
            illegal_q   <= illegal_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign hi        = hi_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

endmodule
